// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, 8N1 framing with optional parity.
// Delivers each byte with a one-cycle RX_valid strobe plus parity and framing error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RX_in,
    output logic [7:0] RX_data,
    output logic       RX_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int              CW      = $clog2(CLKS_PER_BIT);
    localparam int              HALF    = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0]   HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0]   LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic            ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_perr;
    logic            r_sync1;
    logic            r_rx_s;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_parity_err;
    logic            r_frame_err;
    logic            r_busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_sync1      <= 1'b1;
            r_rx_s       <= 1'b1;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync1 <= RX_in;
            r_rx_s  <= r_sync1;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                        r_perr  <= 1'b0;
                    end
                end
                // Re-check the start bit at its midpoint to reject short glitches
                S_START: begin
                    if (r_clk_cnt == HALF_M1) begin
                        r_clk_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == LAST) begin
                        r_clk_cnt          <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) r_state <= S_PARITY;
                            else                r_state <= S_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (r_clk_cnt == LAST) begin
                        r_clk_cnt <= '0;
                        r_perr    <= (((^r_shift) ^ r_rx_s) != ODD_BIT);
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                // Frames with errors still strobe; a low stop bit parks in WAIT_IDLE
                S_STOP: begin
                    if (r_clk_cnt == LAST) begin
                        r_clk_cnt    <= '0;
                        r_data       <= r_shift;
                        r_parity_err <= r_perr;
                        r_frame_err  <= ~r_rx_s;
                        r_valid      <= 1'b1;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    r_clk_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign RX_data    = r_data;
    assign RX_valid   = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, even parity enabled.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       RX_in = 1'b1;
    logic [7:0] RX_data;
    logic       RX_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc;
    int prev_valid = 0;
    int busy_after = 1;

    logic [7:0] hist_data[$];
    int         hist_cyc[$];
    logic       hist_p[$];
    logic       hist_f[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk(clk), .reset_n(reset_n), .RX_in(RX_in), .RX_data(RX_data),
        .RX_valid(RX_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_valid != 0) busy_after = int'(busy);
        prev_valid = int'(RX_valid);
        if (RX_valid) begin
            hist_data.push_back(RX_data);
            hist_cyc.push_back(cyc);
            hist_p.push_back(parity_err);
            hist_f.push_back(frame_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RX_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(RX_data), 32'h00);
        chk("rst_valid", 32'(RX_valid), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 0xA5, correct even parity 0, good stop
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("a5_count", 32'(hist_data.size()), 32'd1);
        chk("a5_data", 32'(hist_data[0]), 32'hA5);
        chk("a5_perr", 32'(hist_p[0]), 32'h0);
        chk("a5_ferr", 32'(hist_f[0]), 32'h0);
        chk("a5_latency", 32'((hist_cyc[0] - start_cyc >= 169) && (hist_cyc[0] - start_cyc <= 171)), 32'h1);
        chk("a5_busy_after", 32'(busy_after), 32'h0);

        // 0x3C with wrong parity bit
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("3c_count", 32'(hist_data.size()), 32'd2);
        chk("3c_data", 32'(RX_data), 32'h3C);
        chk("3c_perr", 32'(parity_err), 32'h1);
        chk("3c_ferr", 32'(frame_err), 32'h0);

        // 0xFF with stop bit low, line held low afterwards
        send_frame(8'hFF, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("ff_count", 32'(hist_data.size()), 32'd3);
        chk("ff_data", 32'(RX_data), 32'hFF);
        chk("ff_ferr", 32'(frame_err), 32'h1);
        chk("ff_perr", 32'(parity_err), 32'h0);
        chk("ff_busy_wait", 32'(busy), 32'h1);
        RX_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("ff_busy_release", 32'(busy), 32'h0);
        chk("ff_no_second", 32'(hist_data.size()), 32'd3);

        // Glitch shorter than half a bit
        repeat (4) @(posedge clk);
        #1;
        RX_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        RX_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("glitch_busy_lo", 32'(busy), 32'h0);
        chk("glitch_no_valid", 32'(hist_data.size()), 32'd3);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_count", 32'(hist_data.size()), 32'd5);
        chk("b2b_data0", 32'(hist_data[3]), 32'h00);
        chk("b2b_data1", 32'(hist_data[4]), 32'h81);
        chk("b2b_spacing", 32'(hist_cyc[4] - hist_cyc[3]), 32'd176);
        chk("b2b_flags0", 32'({hist_p[3], hist_f[3]}), 32'h0);
        chk("b2b_flags1", 32'({hist_p[4], hist_f[4]}), 32'h0);

        // Reset after the 4th data bit of a frame, released with the line idle
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        RX_in = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("mid_rst_data", 32'(RX_data), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_flags", 32'({RX_valid, parity_err, frame_err}), 32'h0);
        repeat (200) @(posedge clk);
        #1;
        chk("mid_rst_no_valid", 32'(hist_data.size()), 32'd5);
        chk("mid_rst_idle_busy", 32'(busy), 32'h0);
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("5a_count", 32'(hist_data.size()), 32'd6);
        chk("5a_data", 32'(RX_data), 32'h5A);
        chk("5a_perr", 32'(parity_err), 32'h0);
        chk("5a_ferr", 32'(frame_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path; the counterpart of the transmit top.
- Consumes the serial line driven by the transmitter, either looped back or from the board pin.
- Oversamples with the system clock, samples mid-bit and reassembles a frame of 1 start bit, 8 data bits (LSB first), optional parity and 1 stop bit.
- Delivers each received byte with a one-cycle valid strobe plus error flags to downstream logic (LEDs/7-seg or FIFO).

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud); must be ≥ 4.
- PARITY_EN, 1, 1 = a parity bit follows data bit 7; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity check; 1 = odd parity check. Ignored if PARITY_EN = 0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- RX_in  input  1  asynchronous serial line; idle high.
- RX_data  output  8  last received data byte.
- RX_valid  output  1  one-cycle strobe: RX_data and the flags updated.
- parity_err  output  1  parity mismatch for the frame in RX_data; 0 when PARITY_EN = 0.
- frame_err  output  1  stop bit sampled low for the frame in RX_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock and one reset, as already decided. Synchronous active-low reset (reset_n sampled on clk edge) overrides everything at any time, including mid-frame.
  - State returns to IDLE; counters and shift register clear.
  - Synchronizer flops set to 1.
  - RX_data = 0x00, RX_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
- Input: RX_in passes through a 2-flop synchronizer (reset value 1). All logic uses only the synchronized signal rx_s.
- Counter: clk_cnt, width $clog2(CLKS_PER_BIT). Cleared on every state change. HALF = CLKS_PER_BIT/2 (integer division).
- States:
  - IDLE: busy = 0. rx_s == 0 → START.
  - START: when clk_cnt == HALF-1, sample rx_s.
    - 0 → DATA, bit_idx = 0.
    - 1 (glitch shorter than half a bit) → IDLE. No strobe, no flags.
  - DATA: when clk_cnt == CLKS_PER_BIT-1, shift rx_s into shift[bit_idx] and increment bit_idx.
    - After bit 7: → PARITY if PARITY_EN, else → STOP.
  - PARITY: when clk_cnt == CLKS_PER_BIT-1, capture the parity bit.
    - perr = (^shift ^ par_bit) != PARITY_ODD.
    - → STOP.
  - STOP: when clk_cnt == CLKS_PER_BIT-1, sample the stop bit. On that edge register:
    - RX_data = shift
    - parity_err = perr
    - frame_err = ~rx_s
    - RX_valid = 1 for exactly one cycle
    - Then: stop bit = 1 → IDLE; stop bit = 0 → WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s == 1, then → IDLE. Prevents a break condition being read as back-to-back start bits.
- Flag behaviour: RX_data, parity_err and frame_err hold their values until the next RX_valid. A frame with errors still strobes RX_valid.
- Back-to-back frames: a start edge in the cycle immediately after the return to IDLE is accepted. There is no dead time beyond the state transition.
- Timing: RX_valid rises 2 + HALF + (9 + PARITY_EN)·CLKS_PER_BIT cycles after the RX_in falling edge, ±1 cycle.

Test Plan:
- CLKS_PER_BIT=16, PARITY_EN=1, even. Send 0xA5 with parity 0 and stop 1 → RX_valid pulses once, ~170 clks after the start edge; RX_data=0xA5, parity_err=0, frame_err=0; busy falls the cycle after.
- Same config, send 0x3C with parity bit 1 (wrong) → RX_data=0x3C, parity_err=1, frame_err=0.
- Send 0xFF with stop bit 0, then hold the line low for 40 clks → RX_valid once, frame_err=1; FSM stays in WAIT_IDLE (busy=1) until the line goes high; no second strobe.
- Glitch: drive RX_in low for 5 clks, then high → no RX_valid; busy returns to 0 within 10 clks.
- Back-to-back: send 0x00 then 0x81 with no idle gap → two strobes 11·16 clks apart; data 0x00 then 0x81, no errors.
- Assert reset_n=0 for 1 clk after the 4th data bit of a frame, then release while the line is idle → outputs read 0; no RX_valid for the aborted frame; the next clean frame 0x5A is received correctly.
